// File: rtl/weight_read_sequencer.sv
// Weight read sequencer: walks one neuron's weight memory once per pass,
// pairing each accepted input feature with the weight read at the matching
// address. A single output register stage absorbs the memory's 1-cycle read
// latency, so every pair appears exactly one cycle after its feature is
// accepted.
module weight_read_sequencer #(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [dataWidth-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    mem_ren,
  output logic [addressWidth:0]   mem_raddr,
  input  logic [dataWidth-1:0]    mem_wout,
  output logic [dataWidth-1:0]    out_data,
  output logic [dataWidth-1:0]    out_weight,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int                   CntWidth = addressWidth + 1;
  localparam logic [CntWidth-1:0]  LastIdx  = CntWidth'(numWeight - 1);
  localparam logic [CntWidth-1:0]  CntOne   = CntWidth'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CntWidth-1:0] cnt;
  logic                accept;
  logic                take;
  logic                at_last;

  // A feature may enter only while the output slot is free or being emptied
  // this cycle; this single condition provides both back-pressure and the
  // 1 pair/cycle streaming rate.
  assign in_ready   = (state == RUN) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign take       = out_valid && out_ready;
  assign at_last    = (cnt == LastIdx);

  // The memory read is issued in the accept cycle, so its data lands in the
  // same cycle the registered feature does; the weight is passed straight
  // through and stays stable during stalls because no new read is issued.
  assign mem_ren    = accept;
  assign mem_raddr  = cnt;
  assign out_weight = mem_wout;

  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    // NOTE: default assigned first so every path drives state_next and no
    // latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (start)                state_next = RUN;
      RUN:     if (accept && at_last)    state_next = DRAIN;
      DRAIN:   if (take && out_last)     state_next = DONE;
      DONE:                              state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Address counter and output pair register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (abort) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        // A new pair replaces the old one even if it is taken this cycle,
        // so out_valid stays high while streaming.
        out_data  <= in_data;
        out_valid <= 1'b1;
        out_last  <= at_last;
        // The counter stops at the last index; it never wraps within a pass.
        if (!at_last) cnt <= cnt + CntOne;
      end else if (take) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        // Clearing on the final hand-off leaves cnt at 0 for DONE and IDLE.
        if (out_last) cnt <= '0;
      end
      if ((state == IDLE) && start) cnt <= '0;
    end
  end

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Directed bench for weight_read_sequencer: a 4-weight instance covers the
// streaming, stall, bubble, abort and reset scenarios; a 1-weight instance
// covers the single-pair pass. Each instance gets a 1-cycle-latency weight
// memory model that holds its output while no read is issued.
module tb_weight_read_sequencer;

  logic clk;
  logic rst;

  // 4-weight instance
  logic        start, abort, in_valid, in_ready, mem_ren, out_valid, out_last;
  logic        out_ready, busy, done;
  logic [15:0] in_data, mem_wout, out_data, out_weight;
  logic [10:0] mem_raddr;

  // 1-weight instance
  logic        s1_start, s1_abort, s1_in_valid, s1_in_ready, s1_mem_ren;
  logic        s1_out_valid, s1_out_last, s1_out_ready, s1_busy, s1_done;
  logic [15:0] s1_in_data, s1_mem_wout, s1_out_data, s1_out_weight;
  logic [10:0] s1_mem_raddr;

  int checks   = 0;
  int failures = 0;

  // Per-cycle stimulus patterns and observation log for stream runs.
  bit          vpat [16];
  bit          rpat [16];
  logic        log_ov [16], log_ol [16], log_ir [16], log_ren [16];
  logic        log_done [16], log_busy [16];
  logic [15:0] log_od [16], log_ow [16];
  logic [10:0] log_addr [16];

  weight_read_sequencer #(.numWeight(4), .addressWidth(10), .dataWidth(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_wout(mem_wout),
    .out_data(out_data), .out_weight(out_weight), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done)
  );

  weight_read_sequencer #(.numWeight(1), .addressWidth(10), .dataWidth(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .abort(s1_abort),
    .in_data(s1_in_data), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .mem_ren(s1_mem_ren), .mem_raddr(s1_mem_raddr), .mem_wout(s1_mem_wout),
    .out_data(s1_out_data), .out_weight(s1_out_weight), .out_valid(s1_out_valid),
    .out_last(s1_out_last), .out_ready(s1_out_ready), .busy(s1_busy), .done(s1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memories: 10,20,30,40 and a single 5; 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_ren)
      mem_wout <= (mem_raddr < 11'd4) ? 16'(10 * (int'(mem_raddr) + 1)) : 16'hDEAD;
    if (s1_mem_ren)
      s1_mem_wout <= (s1_mem_raddr == 11'd0) ? 16'd5 : 16'hDEAD;
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drive n cycles from vpat/rpat, feeding features 1,2,3,... in order and
  // logging outputs mid-cycle. Entered and left at posedge+1.
  task automatic run(input int n);
    int feat = 1;
    for (int c = 0; c < n; c++) begin
      in_valid  = vpat[c];
      in_data   = 16'(feat);
      out_ready = rpat[c];
      @(negedge clk);
      log_ov[c]   = out_valid;  log_ol[c]  = out_last;  log_ir[c]   = in_ready;
      log_ren[c]  = mem_ren;    log_done[c] = done;     log_busy[c] = busy;
      log_od[c]   = out_data;   log_ow[c]  = out_weight; log_addr[c] = mem_raddr;
      if (in_valid && in_ready) feat++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    checks++; if (out_last !== 1'b0)  begin failures++; $display("FAIL reset out_last got %b exp 0", out_last); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset done got %b exp 0", done); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL reset in_ready got %b exp 0", in_ready); end
    checks++; if (out_data !== 16'd0) begin failures++; $display("FAIL reset out_data got %0d exp 0", out_data); end
    checks++; if (mem_raddr !== 11'd0) begin failures++; $display("FAIL reset mem_raddr got %0d exp 0", mem_raddr); end
    checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("FAIL reset s1_out_valid got %b exp 0", s1_out_valid); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_pass();
    int e_ov  [7] = '{0, 1, 1, 1, 1, 0, 0};
    int e_od  [7] = '{0, 1, 2, 3, 4, 0, 0};
    int e_ol  [7] = '{0, 0, 0, 0, 1, 0, 0};
    int e_ad  [7] = '{0, 1, 2, 3, 3, 0, 0};
    int e_ir  [7] = '{1, 1, 1, 1, 0, 0, 0};
    int e_dn  [7] = '{0, 0, 0, 0, 0, 1, 0};
    int e_by  [7] = '{1, 1, 1, 1, 1, 0, 0};
    for (int c = 0; c < 16; c++) begin vpat[c] = (c < 4); rpat[c] = 1'b1; end
    do_start();
    run(7);
    for (int c = 0; c < 7; c++) begin
      checks++; if (log_ov[c] !== 1'(e_ov[c])) begin failures++; $display("FAIL basic c%0d out_valid got %b exp %0d", c, log_ov[c], e_ov[c]); end
      if (e_ov[c] != 0) begin
        checks++; if (log_od[c] !== 16'(e_od[c])) begin failures++; $display("FAIL basic c%0d out_data got %0d exp %0d", c, log_od[c], e_od[c]); end
        checks++; if (log_ow[c] !== 16'(10 * e_od[c])) begin failures++; $display("FAIL basic c%0d out_weight got %0d exp %0d", c, log_ow[c], 10 * e_od[c]); end
        checks++; if (log_ol[c] !== 1'(e_ol[c])) begin failures++; $display("FAIL basic c%0d out_last got %b exp %0d", c, log_ol[c], e_ol[c]); end
      end
      checks++; if (log_addr[c] !== 11'(e_ad[c])) begin failures++; $display("FAIL basic c%0d mem_raddr got %0d exp %0d", c, log_addr[c], e_ad[c]); end
      checks++; if (log_ir[c] !== 1'(e_ir[c])) begin failures++; $display("FAIL basic c%0d in_ready got %b exp %0d", c, log_ir[c], e_ir[c]); end
      checks++; if (log_ren[c] !== 1'(e_ir[c] & int'(vpat[c]))) begin failures++; $display("FAIL basic c%0d mem_ren got %b", c, log_ren[c]); end
      checks++; if (log_done[c] !== 1'(e_dn[c])) begin failures++; $display("FAIL basic c%0d done got %b exp %0d", c, log_done[c], e_dn[c]); end
      checks++; if (log_busy[c] !== 1'(e_by[c])) begin failures++; $display("FAIL basic c%0d busy got %b exp %0d", c, log_busy[c], e_by[c]); end
    end
  endtask

  task automatic test_stall();
    int r_pat [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    int e_ov  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int e_od  [9] = '{0, 1, 2, 2, 2, 2, 3, 4, 0};
    int e_ol  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    int e_ad  [9] = '{0, 1, 2, 2, 2, 2, 3, 3, 0};
    int e_ir  [9] = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
    int e_dn  [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    int taken = 0;
    for (int c = 0; c < 16; c++) begin vpat[c] = 1'b1; rpat[c] = (c < 9) ? r_pat[c][0] : 1'b1; end
    do_start();
    run(9);
    for (int c = 0; c < 9; c++) begin
      checks++; if (log_ov[c] !== 1'(e_ov[c])) begin failures++; $display("FAIL stall c%0d out_valid got %b exp %0d", c, log_ov[c], e_ov[c]); end
      if (e_ov[c] != 0) begin
        checks++; if (log_od[c] !== 16'(e_od[c])) begin failures++; $display("FAIL stall c%0d out_data got %0d exp %0d", c, log_od[c], e_od[c]); end
        checks++; if (log_ow[c] !== 16'(10 * e_od[c])) begin failures++; $display("FAIL stall c%0d out_weight got %0d exp %0d", c, log_ow[c], 10 * e_od[c]); end
        checks++; if (log_ol[c] !== 1'(e_ol[c])) begin failures++; $display("FAIL stall c%0d out_last got %b exp %0d", c, log_ol[c], e_ol[c]); end
      end
      checks++; if (log_addr[c] !== 11'(e_ad[c])) begin failures++; $display("FAIL stall c%0d mem_raddr got %0d exp %0d", c, log_addr[c], e_ad[c]); end
      checks++; if (log_ir[c] !== 1'(e_ir[c])) begin failures++; $display("FAIL stall c%0d in_ready got %b exp %0d", c, log_ir[c], e_ir[c]); end
      checks++; if (log_ren[c] !== 1'(e_ir[c])) begin failures++; $display("FAIL stall c%0d mem_ren got %b exp %0d", c, log_ren[c], e_ir[c]); end
      checks++; if (log_done[c] !== 1'(e_dn[c])) begin failures++; $display("FAIL stall c%0d done got %b exp %0d", c, log_done[c], e_dn[c]); end
      if (log_ov[c] === 1'b1 && rpat[c]) taken++;
    end
    checks++; if (taken !== 4) begin failures++; $display("FAIL stall pairs_taken got %0d exp 4", taken); end
  endtask

  task automatic test_bubbles();
    int v_pat [9] = '{1, 0, 0, 1, 1, 0, 1, 0, 0};
    int e_ov  [9] = '{0, 1, 0, 0, 1, 1, 0, 1, 0};
    int e_od  [9] = '{0, 1, 0, 0, 2, 3, 0, 4, 0};
    int e_ol  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    int e_ad  [9] = '{0, 1, 1, 1, 2, 3, 3, 3, 0};
    int e_ren [9] = '{1, 0, 0, 1, 1, 0, 1, 0, 0};
    int e_dn  [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int c = 0; c < 16; c++) begin vpat[c] = (c < 9) ? v_pat[c][0] : 1'b0; rpat[c] = 1'b1; end
    do_start();
    run(9);
    for (int c = 0; c < 9; c++) begin
      checks++; if (log_ov[c] !== 1'(e_ov[c])) begin failures++; $display("FAIL bubble c%0d out_valid got %b exp %0d", c, log_ov[c], e_ov[c]); end
      if (e_ov[c] != 0) begin
        checks++; if (log_od[c] !== 16'(e_od[c])) begin failures++; $display("FAIL bubble c%0d out_data got %0d exp %0d", c, log_od[c], e_od[c]); end
        checks++; if (log_ow[c] !== 16'(10 * e_od[c])) begin failures++; $display("FAIL bubble c%0d out_weight got %0d exp %0d", c, log_ow[c], 10 * e_od[c]); end
        checks++; if (log_ol[c] !== 1'(e_ol[c])) begin failures++; $display("FAIL bubble c%0d out_last got %b exp %0d", c, log_ol[c], e_ol[c]); end
      end
      checks++; if (log_addr[c] !== 11'(e_ad[c])) begin failures++; $display("FAIL bubble c%0d mem_raddr got %0d exp %0d", c, log_addr[c], e_ad[c]); end
      checks++; if (log_ren[c] !== 1'(e_ren[c])) begin failures++; $display("FAIL bubble c%0d mem_ren got %b exp %0d", c, log_ren[c], e_ren[c]); end
      checks++; if (log_done[c] !== 1'(e_dn[c])) begin failures++; $display("FAIL bubble c%0d done got %b exp %0d", c, log_done[c], e_dn[c]); end
    end
  endtask

  task automatic test_abort();
    for (int c = 0; c < 16; c++) begin vpat[c] = 1'b1; rpat[c] = 1'b1; end
    do_start();
    run(2);
    // Third feature offered together with abort and start: abort wins.
    abort = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 16'd3;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL abort busy got %b exp 0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort out_valid got %b exp 0", out_valid); end
    checks++; if (out_last !== 1'b0)  begin failures++; $display("FAIL abort out_last got %b exp 0", out_last); end
    checks++; if (mem_raddr !== 11'd0) begin failures++; $display("FAIL abort mem_raddr got %0d exp 0", mem_raddr); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort done c%0d got %b exp 0", c, done); end
      @(negedge clk);
    end
    @(posedge clk); #1;
    do_start();
    run(7);
    checks++; if (log_addr[0] !== 11'd0) begin failures++; $display("FAIL abort restart mem_raddr got %0d exp 0", log_addr[0]); end
    checks++; if (log_od[1] !== 16'd1 || log_ow[1] !== 16'd10) begin failures++; $display("FAIL abort restart pair got (%0d,%0d) exp (1,10)", log_od[1], log_ow[1]); end
    checks++; if (log_done[5] !== 1'b1) begin failures++; $display("FAIL abort restart done got %b exp 1", log_done[5]); end
  endtask

  task automatic test_start_and_reset();
    for (int c = 0; c < 16; c++) begin vpat[c] = 1'b1; rpat[c] = 1'b1; end
    do_start();
    run(2);
    start = 1'b1; in_valid = 1'b1; in_data = 16'd3; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_raddr !== 11'd2) begin failures++; $display("FAIL start_in_run mem_raddr got %0d exp 2", mem_raddr); end
    checks++; if (mem_ren !== 1'b1)    begin failures++; $display("FAIL start_in_run mem_ren got %b exp 1", mem_ren); end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_data !== 16'd3 || out_weight !== 16'd30) begin failures++; $display("FAIL start_in_run pair got (%0d,%0d) exp (3,30)", out_data, out_weight); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_in_run busy got %b exp 1", busy); end
    #1 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 16'd0) begin failures++; $display("FAIL midreset out_data got %0d exp 0", out_data); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL midreset busy got %b exp 0", busy); end
    checks++; if (mem_raddr !== 11'd0) begin failures++; $display("FAIL midreset mem_raddr got %0d exp 0", mem_raddr); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0 || mem_ren !== 1'b0) begin failures++; $display("FAIL post_reset c%0d in_ready/mem_ren got %b/%b exp 0/0", c, in_ready, mem_ren); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    do_start();
    run(7);
    checks++; if (log_addr[0] !== 11'd0 || log_ren[0] !== 1'b1) begin failures++; $display("FAIL post_reset restart raddr/ren got %0d/%b exp 0/1", log_addr[0], log_ren[0]); end
    checks++; if (log_done[5] !== 1'b1) begin failures++; $display("FAIL post_reset restart done got %b exp 1", log_done[5]); end
  endtask

  task automatic test_single_weight();
    s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0; s1_in_valid = 1'b1; s1_in_data = 16'd7; s1_out_ready = 1'b1;
    @(negedge clk);
    checks++; if (s1_mem_ren !== 1'b1 || s1_mem_raddr !== 11'd0) begin failures++; $display("FAIL single accept ren/raddr got %b/%0d exp 1/0", s1_mem_ren, s1_mem_raddr); end
    @(posedge clk); #1;
    s1_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (s1_out_valid !== 1'b1) begin failures++; $display("FAIL single out_valid got %b exp 1", s1_out_valid); end
    checks++; if (s1_out_data !== 16'd7 || s1_out_weight !== 16'd5) begin failures++; $display("FAIL single pair got (%0d,%0d) exp (7,5)", s1_out_data, s1_out_weight); end
    checks++; if (s1_out_last !== 1'b1) begin failures++; $display("FAIL single out_last got %b exp 1", s1_out_last); end
    checks++; if (s1_in_ready !== 1'b0) begin failures++; $display("FAIL single drain in_ready got %b exp 0", s1_in_ready); end
    @(negedge clk);
    checks++; if (s1_done !== 1'b1 || s1_out_valid !== 1'b0) begin failures++; $display("FAIL single done/out_valid got %b/%b exp 1/0", s1_done, s1_out_valid); end
    @(negedge clk);
    checks++; if (s1_done !== 1'b0 || s1_busy !== 1'b0) begin failures++; $display("FAIL single idle done/busy got %b/%b exp 0/0", s1_done, s1_busy); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    s1_start = 1'b0; s1_abort = 1'b0; s1_in_valid = 1'b0; s1_in_data = '0; s1_out_ready = 1'b1;
    test_reset();
    test_basic_pass();
    test_stall();
    test_bubbles();
    test_abort();
    test_start_and_reset();
    test_single_weight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
